// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the receive-side rate-change sequencer.
// The optional timeout path is enabled with RX_RATE_TIMEOUT_EN (see rx_rate_ctrl).
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        WAIT_PHY = 3'd2,
        SETTLE   = 3'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        GEN1 = 3'd1,
        GEN2 = 3'd2,
        GEN3 = 3'd3,
        GEN4 = 3'd4,
        GEN5 = 3'd5
    } gen_e;

    localparam logic [2:0] GEN_MIN   = GEN1;
    localparam logic [2:0] GEN_MAX   = GEN5;
    localparam int         MAX_LANES = 16;

    function automatic logic gen_legal(input logic [2:0] g);
        return (g >= GEN_MIN) && (g <= GEN_MAX);
    endfunction

    // A lane count of zero still keeps lane 0 alive.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [4:0] n);
        logic [MAX_LANES-1:0] m;
        if (n == 5'd0)
            m = MAX_LANES'(1);
        else if (n >= 5'(MAX_LANES))
            m = '1;
        else
            m = (MAX_LANES'(1) << n) - MAX_LANES'(1);
        return m;
    endfunction

endpackage

// File: rtl/rx_lane_status_tracker.sv
// Active-lane mask and sticky per-lane PhyStatus capture.
// all_done already includes the current cycle's PhyStatus.
module rx_lane_status_tracker
    import rx_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_mask,
    input  logic [4:0]           lane_count,
    input  logic                 clear,
    input  logic                 capture,
    input  logic [MAX_LANES-1:0] phy_status,
    output logic [MAX_LANES-1:0] active,
    output logic                 all_done
);

    logic [MAX_LANES-1:0] sticky;
    logic [MAX_LANES-1:0] sticky_next;

    assign sticky_next = sticky | (phy_status & active);
    assign all_done    = capture && (sticky_next == active);

    always_ff @(posedge clk) begin
        if (!reset) begin
            active <= '0;
            sticky <= '0;
        end else begin
            if (load_mask)
                active <= lane_mask(lane_count);
            if (clear)
                sticky <= '0;
            else if (capture)
                sticky <= sticky_next;
        end
    end

endmodule

// File: rtl/rx_rate_ctrl.sv
// Rate-change sequencer: hold and drain the rx datapath, switch GEN, wait for PhyStatus and RxValid.
// Define RX_RATE_TIMEOUT_EN to add the WAIT_PHY/SETTLE timeout with GEN revert.
//
// state    | meaning
// IDLE     | ready for a request, datapath released
// DRAIN    | datapath held, pipeline draining before GEN switch
// WAIT_PHY | new GEN applied, collecting PhyStatus from active lanes
// SETTLE   | waiting for consecutive all-lanes RxValid cycles
module rx_rate_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int INIT_GEN       = 1,
    parameter int DRAIN_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1023
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           target_gen,
    input  logic [4:0]           numberOfDetectedLanes,
    input  logic [MAX_LANES-1:0] PhyStatus,
    input  logic [MAX_LANES-1:0] RxValid,
    output logic [2:0]           cur_gen,
    output logic                 datapath_hold,
    output logic                 lmc_flush,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           state
);

    localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] SETTLE_DONE = 8'(SETTLE_CYCLES);

    if (INIT_GEN < 1 || INIT_GEN > 5 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 ||
        SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("rx_rate_ctrl: parameter out of range");
    end

`ifdef RX_RATE_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    rx_state_e            state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           target_q, target_d;
    logic [2:0]           old_gen_q, old_gen_d;
    logic [2:0]           gen_q, gen_d;
    logic                 ready_q, hold_q, flush_q, done_q, err_q;
    logic                 done_d, err_d;
    logic                 accept, trk_clear, phy_all, all_valid;
    logic [MAX_LANES-1:0] active;

    assign accept    = req_valid && ready_q;
    assign all_valid = (RxValid & active) == active;

    rx_lane_status_tracker u_lanes (
        .clk        (clk),
        .reset      (reset),
        .load_mask  (accept),
        .lane_count (numberOfDetectedLanes),
        .clear      (trk_clear),
        .capture    (state_q == WAIT_PHY),
        .phy_status (PhyStatus),
        .active     (active),
        .all_done   (phy_all)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        old_gen_d = old_gen_q;
        gen_d     = gen_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        trk_clear = 1'b0;
`ifdef RX_RATE_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!gen_legal(target_gen)) begin
                        err_d = 1'b1;
                    end else if (target_gen == gen_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d  = target_gen;
                        old_gen_d = gen_q;
                        cnt_d     = '0;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d     = '0;
                    gen_d     = target_q;
                    trk_clear = 1'b1;
                    state_d   = WAIT_PHY;
`ifdef RX_RATE_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_PHY: begin
                if (phy_all)
                    state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_DONE) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (all_valid) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef RX_RATE_TIMEOUT_EN
        // A completion landing on the timeout cycle wins; done and err stay exclusive.
        if (state_q == WAIT_PHY || state_q == SETTLE) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_q == TMO_LAST && !done_d) begin
                tmo_d   = '0;
                cnt_d   = '0;
                gen_d   = old_gen_q;
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            target_q  <= 3'(INIT_GEN);
            old_gen_q <= 3'(INIT_GEN);
            gen_q     <= 3'(INIT_GEN);
            ready_q   <= 1'b1;
            hold_q    <= 1'b0;
            flush_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef RX_RATE_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            old_gen_q <= old_gen_d;
            gen_q     <= gen_d;
            ready_q   <= (state_d == IDLE);
            hold_q    <= (state_d != IDLE);
            flush_q   <= (state_d == WAIT_PHY);
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef RX_RATE_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign req_ready     = ready_q;
    assign datapath_hold = hold_q;
    assign lmc_flush     = flush_q;
    assign done          = done_q;
    assign err           = err_q;
    assign cur_gen       = gen_q;
    assign state         = state_q;

endmodule

// File: tb/tb_rx_rate_ctrl.sv
// Bench for rx_rate_ctrl: directed vector table, hand sequences and randomized requests
// checked against a timeline model of each rate change.
module tb_rx_rate_ctrl;

    localparam int D = 4;
    localparam int S = 8;
`ifdef RX_RATE_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 1023;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  target_gen;
    logic [4:0]  numberOfDetectedLanes;
    logic [15:0] PhyStatus;
    logic [15:0] RxValid;
    logic [2:0]  cur_gen;
    logic        datapath_hold;
    logic        lmc_flush;
    logic        done;
    logic        err;
    logic [2:0]  state;

    always #5 clk = ~clk;

    rx_rate_ctrl #(
        .INIT_GEN       (1),
        .DRAIN_CYCLES   (D),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .target_gen            (target_gen),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .PhyStatus             (PhyStatus),
        .RxValid               (RxValid),
        .cur_gen               (cur_gen),
        .datapath_hold         (datapath_hold),
        .lmc_flush             (lmc_flush),
        .done                  (done),
        .err                   (err),
        .state                 (state)
    );

    typedef struct {
        int tgt;
        int lanes;
        int delay;
        bit stagger;
        int drop_rel;
        bit extra;
        bit noise;
        int exp_edge;
        bit exp_err;
        int exp_gen;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int exp_gen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] pack(input int st, input int gen, input bit rdy,
                                         input bit hold, input bit flush, input bit dn, input bit er);
        return {3'(st), 3'(gen), rdy, hold, flush, dn, er};
    endfunction

    function automatic logic [10:0] outs();
        return {state, cur_gen, req_ready, datapath_hold, lmc_flush, done, err};
    endfunction

    // Edge 0 is the accepting edge; expectations follow from the accept/drain/switch/settle timeline.
    task automatic run_req(input string name, input int tgt, input int lanes, input int arr[16],
                           input int drop_lane, input int drops[2], input bit extra, input bit noise,
                           output int pulse_edge, output bit pulse_err);
        int n, p, base, done_edge, end_edge, old, dl, st, gen, t;
        int dr[2];
        bit legal, same, timeout;
        logic [15:0] m16, ph, rv;
        logic [10:0] exp_v;

        n = (lanes > 16) ? 16 : lanes;
        if (n == 0) n = 1;
        m16 = 16'((32'd1 << n) - 1);
        old = exp_gen;
        legal = (tgt >= 1) && (tgt <= 5);
        same = legal && (tgt == old);
        dl = drop_lane % n;
        dr = drops;
        if (dr[1] >= 0 && (dr[0] < 0 || dr[1] < dr[0])) begin
            t = dr[0]; dr[0] = dr[1]; dr[1] = t;
        end

        p = D;
        for (int i = 0; i < n; i++)
            if (D + arr[i] > p) p = D + arr[i];
        base = p;
        for (int k = 0; k < 2; k++)
            if (dr[k] >= 0 && p + dr[k] > base && p + dr[k] < base + S + 1)
                base = p + dr[k];
        done_edge = base + S + 1;
`ifdef RX_RATE_TIMEOUT_EN
        timeout = (D + TMO) < done_edge;
`else
        timeout = 1'b0;
`endif
        end_edge = (!legal || same) ? 0 : (timeout ? D + TMO : done_edge);

        req_valid = 1'b1;
        target_gen = 3'(tgt);
        numberOfDetectedLanes = 5'(lanes);
        PhyStatus = noise ? (16'($urandom) & ~m16) : 16'h0;
        RxValid = m16 | (noise ? 16'($urandom) : 16'h0);
        pulse_edge = -1;
        pulse_err = 1'b0;

        for (int e = 0; e <= end_edge + 1; e++) begin
            step();
            if (!legal || same) begin
                exp_v = pack(0, old, 1'b1, 1'b0, 1'b0, same && e == 0, !legal && e == 0);
            end else begin
                if (e < D) st = 1;
                else if (e >= end_edge) st = 0;
                else if (e < p) st = 2;
                else st = 3;
                gen = (e < D || (timeout && e >= end_edge)) ? old : tgt;
                exp_v = pack(st, gen, st == 0, st != 0, st == 2,
                             !timeout && e == end_edge, timeout && e == end_edge);
            end
            check($sformatf("%s_e%0d", name, e), 32'(outs()), 32'(exp_v));
            if ((done || err) && pulse_edge < 0) begin
                pulse_edge = e;
                pulse_err = err;
            end

            req_valid = (legal && !same && extra && e + 1 < D);
            if (req_valid) target_gen = 3'($urandom_range(0, 7));
            if (noise) numberOfDetectedLanes = 5'($urandom_range(0, 31));
            ph = 16'h0;
            rv = m16;
            for (int i = 0; i < 16; i++)
                if (m16[i] && e + 1 >= D + arr[i]) ph[i] = 1'b1;
            for (int k = 0; k < 2; k++)
                if (dr[k] >= 0 && e + 1 == p + dr[k]) rv[dl] = 1'b0;
            PhyStatus = ph | (noise ? (16'($urandom) & ~m16) : 16'h0);
            RxValid = rv | (noise ? (16'($urandom) & ~m16) : 16'h0);
        end
        req_valid = 1'b0;
        if (legal && !same && !timeout) exp_gen = tgt;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int arr[16];
        int dr[2];
        int pe;
        bit perr;
        vec_t vecs[10];

        reset = 1'b0;
        req_valid = 1'b0;
        target_gen = 3'd0;
        numberOfDetectedLanes = 5'd0;
        PhyStatus = 16'h0;
        RxValid = 16'h0;
        repeat (3) step();
        check("reset_values", 32'(outs()), 32'(pack(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
        reset = 1'b1;
        exp_gen = 1;

        //          tgt lanes dly stag drop extra noise edge err gen
        vecs[0] = '{3,  4,    2,  0,   -1,  0,    0,    15,  0,  3};
        vecs[1] = '{6,  4,    1,  0,   -1,  0,    0,    0,   1,  3};
        vecs[2] = '{3,  4,    1,  0,   -1,  0,    0,    0,   0,  3};
        vecs[3] = '{0,  4,    1,  0,   -1,  0,    0,    0,   1,  3};
        vecs[4] = '{5,  8,    1,  1,   -1,  0,    1,    21,  0,  5};
        vecs[5] = '{2,  4,    1,  0,   6,   0,    0,    20,  0,  2};
        vecs[6] = '{1,  0,    1,  0,   -1,  1,    0,    14,  0,  1};
        vecs[7] = '{4,  20,   3,  0,   -1,  0,    0,    16,  0,  4};
        vecs[8] = '{7,  4,    1,  0,   -1,  0,    0,    0,   1,  4};
        vecs[9] = '{4,  4,    1,  0,   -1,  0,    0,    0,   0,  4};

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 16; k++)
                arr[k] = vecs[i].stagger ? k + 1 : vecs[i].delay;
            dr[0] = vecs[i].drop_rel;
            dr[1] = -1;
            run_req($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].lanes, arr, 2, dr,
                    vecs[i].extra, vecs[i].noise, pe, perr);
            check($sformatf("vec%0d_pulse_edge", i), 32'(pe), 32'(vecs[i].exp_edge));
            check($sformatf("vec%0d_pulse_err", i), 32'(perr), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_gen", i), 32'(cur_gen), 32'(vecs[i].exp_gen));
            step();
        end

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 16; k++)
                arr[k] = $urandom_range(1, 6);
            dr[0] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1;
            dr[1] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1;
            run_req($sformatf("rnd%0d", r), $urandom_range(0, 7), $urandom_range(0, 20), arr,
                    $urandom_range(0, 15), dr, 1'($urandom_range(0, 1)), 1'b1, pe, perr);
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset in the middle of WAIT_PHY: outputs return to reset values, no pulse.
        for (int k = 0; k < 16; k++) arr[k] = 1;
        req_valid = 1'b1;
        target_gen = (exp_gen == 2) ? 3'd3 : 3'd2;
        numberOfDetectedLanes = 5'd4;
        PhyStatus = 16'h0;
        RxValid = 16'hffff;
        step();
        req_valid = 1'b0;
        repeat (D + 1) step();
        check("rst_mid_state", 32'(state), 32'd2);
        reset = 1'b0;
        step();
        check("rst_mid_outputs", 32'(outs()), 32'(pack(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
        reset = 1'b1;
        step();
        check("rst_mid_after", 32'(outs()), 32'(pack(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
        exp_gen = 1;

`ifdef RX_RATE_TIMEOUT_EN
        for (int k = 0; k < 16; k++) arr[k] = 2;
        arr[1] = 100000;
        dr[0] = -1;
        dr[1] = -1;
        run_req("timeout", 3, 4, arr, 0, dr, 1'b0, 1'b0, pe, perr);
        check("timeout_edge", 32'(pe), 32'(D + TMO));
        check("timeout_err", 32'(perr), 32'd1);
        check("timeout_gen", 32'(cur_gen), 32'd1);
        check("timeout_ready", 32'(req_ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
